sprite_mem_arbiter: RTL and testbench

SPRITE_MEM_ARBITER -- requirements
Module: sprite_mem_arbiter

---
 rtl/sprite_mem_arbiter.sv | 132 +++++++++++++
 tb/tb_sprite_mem_arbiter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/sprite_mem_arbiter.sv
// Shared-memory arbiter between a CPU port and a sprite loader read port.
// Sprite reads are granted in bursts of up to BURST_MAX before a waiting CPU
// access is let in; the CPU gets at most STARVE_MAX back-to-back grants while
// a sprite read waits. Read data comes back one cycle after mem_read and is
// steered by a registered owner flag.
module sprite_mem_arbiter #(
   parameter int unsigned BURST_MAX  = 8,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cpu_read,
   input  logic        cpu_write,
   input  logic [15:0] cpu_address,
   input  logic [31:0] cpu_wdata,
   output logic        cpu_stall,
   output logic        cpu_rvalid,
   output logic [31:0] cpu_rdata,
   input  logic        spr_read,
   input  logic [15:0] spr_address,
   output logic        spr_grant,
   output logic        spr_rvalid,
   output logic [31:0] spr_rdata,
   output logic        mem_read,
   output logic        mem_write,
   output logic [15:0] mem_address,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   localparam int unsigned BW = $clog2(BURST_MAX + 1);
   localparam int unsigned SW = $clog2(STARVE_MAX + 1);
   localparam logic [BW-1:0] BurstMaxC  = BW'(BURST_MAX);
   localparam logic [SW-1:0] StarveMaxC = SW'(STARVE_MAX);

   typedef enum logic [0:0] {StArb, StSprBurst} state_e;

   state_e        state_q, state_d;
   logic [BW-1:0] burst_cnt_q, burst_cnt_d;
   logic [SW-1:0] starve_cnt_q, starve_cnt_d;
   logic          cpu_rvalid_q, cpu_rvalid_d;
   logic          spr_rvalid_q, spr_rvalid_d;

   logic cpu_req;
   logic arb_cpu, arb_spr;
   logic cpu_granted, spr_granted;

   assign cpu_req = cpu_read | cpu_write;

   // Arbitration and burst tracking; SPR_BURST with spr_read low falls back
   // to the ARB decision in the same cycle.
   always_comb begin
      state_d     = state_q;
      burst_cnt_d = burst_cnt_q;
      arb_cpu     = 1'b0;
      arb_spr     = 1'b0;
      if (state_q == StSprBurst && spr_read) begin
         if (burst_cnt_q == BurstMaxC && cpu_req) begin
            arb_cpu     = 1'b1;
            state_d     = StArb;
            burst_cnt_d = '0;
         end else begin
            arb_spr = 1'b1;
            if (burst_cnt_q != BurstMaxC) begin
               burst_cnt_d = burst_cnt_q + BW'(1);
            end
         end
      end else begin
         state_d     = StArb;
         burst_cnt_d = '0;
         if (cpu_req && starve_cnt_q < StarveMaxC) begin
            arb_cpu = 1'b1;
         end else if (spr_read) begin
            arb_spr     = 1'b1;
            state_d     = StSprBurst;
            burst_cnt_d = BW'(1);
         end
      end
   end

   // No access is issued while reset is held, whatever the requests say.
   assign cpu_granted = arb_cpu & rst_n;
   assign spr_granted = arb_spr & rst_n;

   // CPU starvation counter: counts CPU wins against a waiting sprite read.
   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (!spr_read || spr_granted) begin
         starve_cnt_d = '0;
      end else if (cpu_granted && starve_cnt_q != StarveMaxC) begin
         starve_cnt_d = starve_cnt_q + SW'(1);
      end
   end

   // Read owner for the data returning next cycle; writes return nothing.
   always_comb begin
      cpu_rvalid_d = cpu_granted & cpu_read;
      spr_rvalid_d = spr_granted;
   end

   // State registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StArb;
         burst_cnt_q  <= '0;
         starve_cnt_q <= '0;
         cpu_rvalid_q <= 1'b0;
         spr_rvalid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         burst_cnt_q  <= burst_cnt_d;
         starve_cnt_q <= starve_cnt_d;
         cpu_rvalid_q <= cpu_rvalid_d;
         spr_rvalid_q <= spr_rvalid_d;
      end
   end

   // Memory port and requester-facing outputs. A write is suppressed if the
   // CPU illegally raises both strobes so the port never sees read+write.
   assign mem_read    = spr_granted | (cpu_granted & cpu_read);
   assign mem_write   = cpu_granted & cpu_write & ~cpu_read;
   assign mem_address = spr_granted ? spr_address : cpu_address;
   assign mem_wdata   = cpu_wdata;

   assign cpu_stall  = cpu_req & ~cpu_granted;
   assign spr_grant  = spr_granted;
   assign cpu_rvalid = cpu_rvalid_q;
   assign spr_rvalid = spr_rvalid_q;
   assign cpu_rdata  = mem_rdata;
   assign spr_rdata  = mem_rdata;

endmodule

// File: tb/tb_sprite_mem_arbiter.sv
// Directed bench for sprite_mem_arbiter with default parameters. Inputs change
// on the falling edge; outputs are sampled 1 ns later.
module tb_sprite_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cpu_read, cpu_write;
   logic [15:0] cpu_address;
   logic [31:0] cpu_wdata;
   logic        cpu_stall, cpu_rvalid;
   logic [31:0] cpu_rdata;
   logic        spr_read;
   logic [15:0] spr_address;
   logic        spr_grant, spr_rvalid;
   logic [31:0] spr_rdata;
   logic        mem_read, mem_write;
   logic [15:0] mem_address;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata = 32'h0;

   int n_total = 0;
   int n_pass  = 0;
   int low_run;

   sprite_mem_arbiter dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cpu_read    (cpu_read),
      .cpu_write   (cpu_write),
      .cpu_address (cpu_address),
      .cpu_wdata   (cpu_wdata),
      .cpu_stall   (cpu_stall),
      .cpu_rvalid  (cpu_rvalid),
      .cpu_rdata   (cpu_rdata),
      .spr_read    (spr_read),
      .spr_address (spr_address),
      .spr_grant   (spr_grant),
      .spr_rvalid  (spr_rvalid),
      .spr_rdata   (spr_rdata),
      .mem_read    (mem_read),
      .mem_write   (mem_write),
      .mem_address (mem_address),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata)
   );

   always #5 clk = ~clk;

   // Memory model: a read returns {A5A5, address} on the following cycle.
   always @(posedge clk) begin
      if (mem_read) mem_rdata <= {16'hA5A5, mem_address};
   end

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
   endtask

   initial begin
      // Reset with both requesters active: nothing may be issued.
      rst_n = 1'b0; cpu_read = 1'b1; cpu_write = 1'b0; cpu_address = 16'h0;
      cpu_wdata = 32'h0; spr_read = 1'b1; spr_address = 16'h0;
      #1;
      chk1("rst_mem_read", mem_read, 1'b0);
      chk1("rst_mem_write", mem_write, 1'b0);
      chk1("rst_spr_grant", spr_grant, 1'b0);
      chk1("rst_cpu_stall", cpu_stall, 1'b1);
      repeat (2) @(posedge clk);
      #1;
      chk1("rst_cpu_rvalid", cpu_rvalid, 1'b0);
      chk1("rst_spr_rvalid", spr_rvalid, 1'b0);
      @(negedge clk);
      rst_n = 1'b1; cpu_read = 1'b0; spr_read = 1'b0;

      // Lone CPU read.
      @(negedge clk);
      cpu_read = 1'b1; cpu_address = 16'h0010;
      #1;
      chk1("cpurd_mem_read", mem_read, 1'b1);
      chk32("cpurd_addr", 32'(mem_address), 32'h0010);
      chk1("cpurd_stall", cpu_stall, 1'b0);
      chk1("cpurd_mem_write", mem_write, 1'b0);
      @(negedge clk);
      cpu_read = 1'b0;
      #1;
      chk1("cpurd_rvalid", cpu_rvalid, 1'b1);
      chk32("cpurd_rdata", cpu_rdata, 32'hA5A5_0010);
      chk1("cpurd_no_spr_rvalid", spr_rvalid, 1'b0);

      // 64 back-to-back sprite reads, CPU idle.
      for (int i = 0; i < 66; i++) begin
         @(negedge clk);
         spr_read = (i < 64); spr_address = 16'h0100 + 16'(i);
         #1;
         chk1("seq_grant", spr_grant, (i < 64));
         if (i < 64) chk32("seq_addr", 32'(mem_address), 32'h0100 + 32'(i));
         chk1("seq_rvalid", spr_rvalid, (i >= 1 && i <= 64));
         if (i >= 1 && i <= 64) chk32("seq_rdata", spr_rdata, 32'hA5A5_0100 + 32'(i) - 32'd1);
      end

      // CPU read raised at sprite grant 3 waits for the end of the 8-burst.
      for (int k = 1; k <= 11; k++) begin
         @(negedge clk);
         spr_read = (k <= 10);
         spr_address = 16'h0200 + 16'((k <= 8) ? k - 1 : 8);
         cpu_read = (k >= 3 && k <= 9); cpu_address = 16'h0040;
         #1;
         chk1("burst_grant", spr_grant, (k <= 8 || k == 10));
         chk1("burst_stall", cpu_stall, (k >= 3 && k <= 8));
         if (k == 9) begin
            chk1("burst_cpu_mem_read", mem_read, 1'b1);
            chk32("burst_cpu_addr", 32'(mem_address), 32'h0040);
         end
         if (k == 10) begin
            chk32("burst_resume_addr", 32'(mem_address), 32'h0208);
            chk1("burst_cpu_rvalid", cpu_rvalid, 1'b1);
            chk32("burst_cpu_rdata", cpu_rdata, 32'hA5A5_0040);
         end
      end

      // CPU every cycle with sprite held: CPU limited to 4 in a row.
      low_run = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         cpu_read = 1'b1; cpu_address = 16'h0060; spr_read = 1'b1; spr_address = 16'h0500;
         #1;
         if (i < 5) begin
            chk1("starve_grant", spr_grant, (i == 4));
            chk1("starve_stall", cpu_stall, (i == 4));
         end
         low_run = spr_grant ? 0 : low_run + 1;
         chk1("starve_gap", (low_run <= 4), 1'b1);
         chk1("starve_busy", mem_read, 1'b1);
      end
      @(negedge clk);
      cpu_read = 1'b0; spr_read = 1'b0;
      @(negedge clk);

      // CPU write and sprite read collide in ARB.
      @(negedge clk);
      cpu_write = 1'b1; cpu_address = 16'h0080; cpu_wdata = 32'hDEAD_BEEF;
      spr_read = 1'b1; spr_address = 16'h0300;
      #1;
      chk1("wr_mem_write", mem_write, 1'b1);
      chk1("wr_mem_read", mem_read, 1'b0);
      chk32("wr_addr", 32'(mem_address), 32'h0080);
      chk32("wr_wdata", mem_wdata, 32'hDEAD_BEEF);
      chk1("wr_spr_grant", spr_grant, 1'b0);
      chk1("wr_stall", cpu_stall, 1'b0);
      @(negedge clk);
      cpu_write = 1'b0;
      #1;
      chk1("wr_no_cpu_rvalid", cpu_rvalid, 1'b0);
      chk1("wr_no_spr_rvalid", spr_rvalid, 1'b0);
      chk1("wr_then_spr_grant", spr_grant, 1'b1);
      chk32("wr_then_spr_addr", 32'(mem_address), 32'h0300);
      @(negedge clk);
      spr_read = 1'b0;
      #1;
      chk1("wr_spr_rvalid", spr_rvalid, 1'b1);
      chk32("wr_spr_rdata", spr_rdata, 32'hA5A5_0300);

      // Reset in the middle of a burst.
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         spr_read = 1'b1; spr_address = 16'h0400 + 16'(k - 1);
         #1;
         chk1("mid_grant", spr_grant, 1'b1);
      end
      chk1("mid_rvalid_before", spr_rvalid, 1'b1);
      rst_n = 1'b0;
      #1;
      chk1("mid_rst_rvalid", spr_rvalid, 1'b0);
      chk1("mid_rst_grant", spr_grant, 1'b0);
      chk1("mid_rst_mem_read", mem_read, 1'b0);
      @(negedge clk);
      rst_n = 1'b1; spr_read = 1'b0; cpu_read = 1'b1; cpu_address = 16'h0050;
      #1;
      chk1("post_rst_mem_read", mem_read, 1'b1);
      chk32("post_rst_addr", 32'(mem_address), 32'h0050);
      chk1("post_rst_stall", cpu_stall, 1'b0);
      chk1("post_rst_no_spr_rvalid", spr_rvalid, 1'b0);
      @(negedge clk);
      cpu_read = 1'b0;
      #1;
      chk1("post_rst_cpu_rvalid", cpu_rvalid, 1'b1);
      chk32("post_rst_cpu_rdata", cpu_rdata, 32'hA5A5_0050);
      chk1("post_rst_spr_rvalid", spr_rvalid, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
